// File: rtl/seq_shift_left.sv
// Multi-cycle logical left shifter (SLL) with a start/busy/done handshake.
// Each clock applies one power-of-two barrel stage, so a 32-bit shift takes five stages.
module seq_shift_left #(
  parameter int unsigned WIDTH    = 32,
  parameter logic [5:0]  SLL_CODE = 6'b000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  input  logic [5:0]       Signal,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dataOut
);

  localparam int unsigned AMT_W      = 5;
  localparam int unsigned CNT_W      = 3;
  localparam int unsigned LAST_STAGE = AMT_W - 1;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [AMT_W-1:0]   amt_q, amt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   dataout_q, dataout_d;

  logic [AMT_W-1:0]   stage_sel;
  logic [AMT_W-1:0]   stage_dist;
  logic [WIDTH-1:0]   stage_res;

  // Only the low five bits of dataB carry the shift amount.
  logic unused_datab;
  assign unused_datab = ^dataB[WIDTH-1:AMT_W];

  // Current barrel stage: shift by 2^cnt when that amount bit is set.
  always_comb begin
    stage_sel  = AMT_W'(1) << cnt_q;
    stage_dist = stage_sel;
    stage_res  = |(amt_q & stage_sel) ? (acc_q << stage_dist) : acc_q;
  end

  // Next-state and output logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    amt_d     = amt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    dataout_d = dataout_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          // A non-SLL code still runs the full latency but yields zero.
          if (Signal == SLL_CODE) begin
            acc_d = dataA;
            amt_d = dataB[AMT_W-1:0];
          end else begin
            acc_d = '0;
            amt_d = '0;
          end
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        acc_d = stage_res;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(LAST_STAGE)) begin
          dataout_d = stage_res;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          cnt_d     = '0;
          state_d   = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      amt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dataout_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      amt_q     <= amt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dataout_q <= dataout_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign dataOut = dataout_q;

endmodule

// File: tb/tb_seq_shift_left.sv
// Self-checking bench for seq_shift_left: directed cases plus randomized operations
// compared against an arithmetic reference model (repeated doubling modulo 2^32).
module tb_seq_shift_left;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic [5:0]  Signal;
  logic        busy;
  logic        done;
  logic [31:0] dataOut;

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;
  logic [31:0] last_out   = 32'h0;

  seq_shift_left #(.WIDTH(32), .SLL_CODE(6'b000000)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .dataA   (dataA),
    .dataB   (dataB),
    .Signal  (Signal),
    .busy    (busy),
    .done    (done),
    .dataOut (dataOut)
  );

  always #5 clk = ~clk;

  // Reference: multiply by two once per unit of shift amount, truncated to 32 bits.
  function automatic logic [31:0] ref_sll(input logic [31:0] a, input logic [31:0] b,
                                          input logic [5:0] sig);
    logic [31:0] r;
    int unsigned n;
    if (sig != 6'd0) return 32'h0;
    n = b % 32;
    r = a;
    for (int i = 0; i < int'(n); i++) r = r * 32'd2;
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one operation and checks every cycle up to and including the done cycle.
  // glitch_at >= 1 pulses start with junk operands after busy step glitch_at.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [5:0] sig, input int glitch_at);
    logic [31:0] exp;
    exp    = ref_sll(a, b, sig);
    start  = 1'b1;
    dataA  = a;
    dataB  = b;
    Signal = sig;
    for (int i = 0; i < 5; i++) begin
      step();
      start  = 1'b0;
      dataA  = $urandom;
      dataB  = $urandom;
      Signal = 6'($urandom);
      check({tag, ":busy"}, 32'(busy), 32'd1);
      check({tag, ":done_low"}, 32'(done), 32'd0);
      check({tag, ":hold"}, dataOut, last_out);
      if (i == glitch_at) begin
        start = 1'b1;
        dataA = 32'hF;
        dataB = 32'd2;
        Signal = 6'd0;
      end
    end
    step();
    start = 1'b0;
    check({tag, ":done"}, 32'(done), 32'd1);
    check({tag, ":busy_low"}, 32'(busy), 32'd0);
    check({tag, ":result"}, dataOut, exp);
    last_out = exp;
  endtask

  task automatic idle_check(input string tag);
    step();
    check({tag, ":done_fall"}, 32'(done), 32'd0);
    check({tag, ":idle_busy"}, 32'(busy), 32'd0);
    check({tag, ":idle_hold"}, dataOut, last_out);
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    dataA  = 32'h0;
    dataB  = 32'h0;
    Signal = 6'h0;
    step();
    step();
    check("rst:busy", 32'(busy), 32'd0);
    check("rst:done", 32'(done), 32'd0);
    check("rst:out", dataOut, 32'h0);
    reset = 1'b0;
    step();

    // Directed cases.
    run_op("amt31", 32'h00000001, 32'd31, 6'h00, -1);
    check("amt31:abs", dataOut, 32'h80000000);
    idle_check("amt31");
    run_op("amt0", 32'hDEADBEEF, 32'd0, 6'h00, -1);
    check("amt0:abs", dataOut, 32'hDEADBEEF);
    idle_check("amt0");
    run_op("amt4", 32'hDEADBEEF, 32'd4, 6'h00, -1);
    check("amt4:abs", dataOut, 32'hEADBEEF0);
    idle_check("amt4");
    run_op("hibits", 32'h12345678, 32'hFFFFFFE8, 6'h00, -1);
    check("hibits:abs", dataOut, 32'h34567800);
    idle_check("hibits");
    run_op("srlcode", 32'hFFFFFFFF, 32'd3, 6'b000010, -1);
    check("srlcode:abs", dataOut, 32'h00000000);
    idle_check("srlcode");

    // Start while busy is ignored.
    run_op("ignore", 32'h1, 32'd1, 6'h00, 1);
    check("ignore:abs", dataOut, 32'h00000002);
    idle_check("ignore");

    // Reset on the third shift edge aborts with no done pulse.
    run_op("pre_rst", 32'h5, 32'd1, 6'h00, -1);
    idle_check("pre_rst");
    start = 1'b1; dataA = 32'h1; dataB = 32'd1; Signal = 6'h00;
    step();
    start = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    last_out = 32'h0;
    check("abort:busy", 32'(busy), 32'd0);
    check("abort:done", 32'(done), 32'd0);
    check("abort:out", dataOut, 32'h0);
    for (int i = 0; i < 6; i++) idle_check("abort");

    // Back-to-back: new start in the done cycle.
    run_op("b2b_a", 32'h00000007, 32'd2, 6'h00, -1);
    run_op("b2b_b", 32'h00000003, 32'd30, 6'h00, -1);
    check("b2b:abs", dataOut, 32'hC0000000);
    idle_check("b2b");

    // Randomized operations, mixing gaps and back-to-back issue.
    for (int n = 0; n < 40; n++) begin
      logic [5:0] sig;
      sig = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(1, 63)) : 6'h00;
      run_op("rand", $urandom, $urandom, sig, ($urandom_range(0, 3) == 0) ? 2 : -1);
      if ($urandom_range(0, 1) == 0) idle_check("rand");
    end
    idle_check("final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
